id_ex_stage: RTL

//  ID/EX pipeline register plus EX-side operand resolution for the 5-stage MIPS core.

---
 rtl/id_ex_stage_pkg.sv | 35 +++
 rtl/id_ex_stage_fwd_mux.sv | 52 +++++
 rtl/id_ex_stage.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_stage_pkg
// Shared definitions for the EX side of the 5-stage MIPS core: ALU function
// codes, immediate extension modes and the field values of a pipeline bubble.
// The ALU, the decoder and the ID/EX stage all import this package, so every
// block agrees on one encoding.
// ----------------------------------------------------------------------------
package id_ex_stage_pkg;

    // ALU function codes. Any code above ALU_SUB is also treated as a subtract
    // by the ALU, so the decoder only ever needs these four.
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3
    } alu_op_e;

    // Immediate extension modes. The fourth code is unused by the decoder and
    // behaves like zero extension, so a stray code never produces garbage.
    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_LUI  = 2'd2,
        EXT_RSVD = 2'd3
    } ext_op_e;

    // A bubble performs "add $0, $0, 0" with every side effect disabled.
    // The ALU function is ADD rather than AND so the bubble looks like the
    // canonical MIPS NOP on a waveform.
    localparam alu_op_e NOP_ALU_OP = ALU_ADD;
    localparam ext_op_e NOP_EXT_OP = EXT_ZERO;
    localparam logic    NOP_CTRL   = 1'b0;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// ----------------------------------------------------------------------------
// fwd_mux
// Resolves one EX source operand against the two in-flight writeback
// candidates. The EX/MEM candidate is younger and therefore wins over MEM/WB.
// Register $0 is hard-wired to zero in the GRF, so it is never forwarded.
//
// Ports
//   reg_addr  in  RADDR_W  source register number held in the stage
//   reg_val   in  WIDTH    registered GRF value for that register
//   fw1_we    in  1        EX/MEM candidate writes the GRF
//   fw1_dst   in  RADDR_W  EX/MEM destination register
//   fw1_val   in  WIDTH    EX/MEM result
//   fw2_we    in  1        MEM/WB candidate writes the GRF
//   fw2_dst   in  RADDR_W  MEM/WB destination register
//   fw2_val   in  WIDTH    MEM/WB result
//   val       out WIDTH    resolved operand value
// ----------------------------------------------------------------------------
module fwd_mux #(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] reg_addr,
    input  logic [WIDTH-1:0]   reg_val,
    input  logic               fw1_we,
    input  logic [RADDR_W-1:0] fw1_dst,
    input  logic [WIDTH-1:0]   fw1_val,
    input  logic               fw2_we,
    input  logic [RADDR_W-1:0] fw2_dst,
    input  logic [WIDTH-1:0]   fw2_val,
    output logic [WIDTH-1:0]   val
);

    logic reg_nonzero;
    logic hit1;
    logic hit2;

    assign reg_nonzero = (reg_addr != '0);
    assign hit1        = fw1_we && (fw1_dst == reg_addr) && reg_nonzero;
    assign hit2        = fw2_we && (fw2_dst == reg_addr) && reg_nonzero;

    // Priority select: the youngest matching producer supplies the value,
    // otherwise the value read from the GRF during ID is used.
    always_comb begin
        val = reg_val;
        if (hit1) begin
            val = fw1_val;
        end else if (hit2) begin
            val = fw2_val;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register and EX-side operand resolution for the 5-stage MIPS
// core. Decoded operands and control are captured from ID on each rising
// edge; in EX the source operands are forwarded from EX/MEM and MEM/WB and
// the 16-bit immediate is extended, producing the ALU operands alu1/alu2 and
// the store data passed on to MEM.
//
// Ports
//   clk, reset_n            clock, synchronous active-low reset
//   flush                   replace the stage with a bubble (branch/exception)
//   hold                    downstream stall; freeze contents, refresh operands
//   bubble                  load-use hazard; take a bubble instead of ID
//   id_valid, id_pc         ID instruction valid flag and PC
//   id_rs, id_rt            source register numbers
//   id_rs_val, id_rt_val    GRF read data
//   id_dst                  destination register number
//   id_imm, id_ext_op       raw immediate and extension mode
//   id_alu_src, id_alu_op   alu2 source select and ALU function
//   id_reg_write, id_mem_write, id_mem_to_reg   instruction control
//   fw1_we/dst/val          EX/MEM writeback candidate (higher priority)
//   fw2_we/dst/val          MEM/WB writeback candidate
//   alu1, alu2              ALU operands (combinational)
//   ALUop                   registered ALU function
//   ex_valid, ex_pc, ex_dst registered instruction state
//   ex_store_val            forwarded rt, store data for MEM
//   ex_reg_write, ex_mem_write, ex_mem_to_reg   registered control
// ----------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int RADDR_W = 5,
    parameter int OP_W    = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               hold,
    input  logic               bubble,
    input  logic               id_valid,
    input  logic [WIDTH-1:0]   id_pc,
    input  logic [RADDR_W-1:0] id_rs,
    input  logic [RADDR_W-1:0] id_rt,
    input  logic [WIDTH-1:0]   id_rs_val,
    input  logic [WIDTH-1:0]   id_rt_val,
    input  logic [RADDR_W-1:0] id_dst,
    input  logic [15:0]        id_imm,
    input  logic [1:0]         id_ext_op,
    input  logic               id_alu_src,
    input  logic [OP_W-1:0]    id_alu_op,
    input  logic               id_reg_write,
    input  logic               id_mem_write,
    input  logic               id_mem_to_reg,
    input  logic               fw1_we,
    input  logic [RADDR_W-1:0] fw1_dst,
    input  logic [WIDTH-1:0]   fw1_val,
    input  logic               fw2_we,
    input  logic [RADDR_W-1:0] fw2_dst,
    input  logic [WIDTH-1:0]   fw2_val,
    output logic [WIDTH-1:0]   alu1,
    output logic [WIDTH-1:0]   alu2,
    output logic [OP_W-1:0]    ALUop,
    output logic               ex_valid,
    output logic [WIDTH-1:0]   ex_pc,
    output logic [WIDTH-1:0]   ex_store_val,
    output logic [RADDR_W-1:0] ex_dst,
    output logic               ex_reg_write,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg
);

    logic [RADDR_W-1:0] rs_q;
    logic [RADDR_W-1:0] rt_q;
    logic [WIDTH-1:0]   rs_val_q;
    logic [WIDTH-1:0]   rt_val_q;
    logic [15:0]        imm_q;
    ext_op_e            ext_op_q;
    logic               alu_src_q;

    logic [WIDTH-1:0]   rs_fwd;
    logic [WIDTH-1:0]   rt_fwd;
    logic [WIDTH-1:0]   imm_ext;
    logic               load_nop;

    // Each source operand gets its own forwarding mux so rs and rt can be
    // satisfied by different producers in the same cycle.
    fwd_mux #(
        .WIDTH   (WIDTH),
        .RADDR_W (RADDR_W)
    ) u_fwd_rs (
        .reg_addr (rs_q),
        .reg_val  (rs_val_q),
        .fw1_we   (fw1_we),
        .fw1_dst  (fw1_dst),
        .fw1_val  (fw1_val),
        .fw2_we   (fw2_we),
        .fw2_dst  (fw2_dst),
        .fw2_val  (fw2_val),
        .val      (rs_fwd)
    );

    fwd_mux #(
        .WIDTH   (WIDTH),
        .RADDR_W (RADDR_W)
    ) u_fwd_rt (
        .reg_addr (rt_q),
        .reg_val  (rt_val_q),
        .fw1_we   (fw1_we),
        .fw1_dst  (fw1_dst),
        .fw1_val  (fw1_val),
        .fw2_we   (fw2_we),
        .fw2_dst  (fw2_dst),
        .fw2_val  (fw2_val),
        .val      (rt_fwd)
    );

    // Immediate extension. The lui form shifts the immediate into the upper
    // halfword; the unused mode code falls back to zero extension.
    always_comb begin
        imm_ext = WIDTH'(imm_q);
        case (ext_op_q)
            EXT_SIGN: imm_ext = {{(WIDTH-16){imm_q[15]}}, imm_q};
            EXT_LUI:  imm_ext = WIDTH'({imm_q, 16'h0000});
            default:  imm_ext = WIDTH'(imm_q);
        endcase
    end

    assign alu1         = rs_fwd;
    assign alu2         = alu_src_q ? imm_ext : rt_fwd;
    assign ex_store_val = rt_fwd;

    // Reset and flush always produce a bubble. Without a stall, a load-use
    // bubble or an invalid ID slot also produce one; a stall with a pending
    // bubble keeps the current instruction, since the ID instruction is held
    // upstream anyway.
    assign load_nop = !reset_n || flush || (!hold && (bubble || !id_valid));

    // Stage register. During a stall only the operand values move: they
    // reload from the forwarding muxes so a producer that retires from
    // MEM/WB while EX is frozen is captured before it disappears.
    always_ff @(posedge clk) begin
        if (load_nop) begin
            ex_valid      <= NOP_CTRL;
            ex_pc         <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            rs_val_q      <= '0;
            rt_val_q      <= '0;
            ex_dst        <= '0;
            imm_q         <= '0;
            ext_op_q      <= NOP_EXT_OP;
            alu_src_q     <= NOP_CTRL;
            ALUop         <= OP_W'(NOP_ALU_OP);
            ex_reg_write  <= NOP_CTRL;
            ex_mem_write  <= NOP_CTRL;
            ex_mem_to_reg <= NOP_CTRL;
        end else if (hold) begin
            rs_val_q      <= rs_fwd;
            rt_val_q      <= rt_fwd;
        end else begin
            ex_valid      <= 1'b1;
            ex_pc         <= id_pc;
            rs_q          <= id_rs;
            rt_q          <= id_rt;
            rs_val_q      <= id_rs_val;
            rt_val_q      <= id_rt_val;
            ex_dst        <= id_dst;
            imm_q         <= id_imm;
            ext_op_q      <= ext_op_e'(id_ext_op);
            alu_src_q     <= id_alu_src;
            ALUop         <= id_alu_op;
            ex_reg_write  <= id_reg_write;
            ex_mem_write  <= id_mem_write;
            ex_mem_to_reg <= id_mem_to_reg;
        end
    end

endmodule
